// File: rtl/prim_sequencer.sv
// prim_sequencer: primitive scheduler in front of the Bresenham line engine.
// Queues draw commands (line / triangle outline / rectangle outline) in a
// small FIFO, splits each into line segments and hands them to the engine
// one at a time, waiting for seg_done between segments.
//
// Ports:
//   clk, n_rst        clock, asynchronous active-low reset
//   cmd_valid/ready   command handshake (ready = FIFO not full)
//   cmd_type          0=line, 1=triangle, 2=rectangle, 3=reserved
//   cmd_v0..v2        vertices {x[9:0], y[8:0]}
//   fb_stall          frame-buffer backpressure, forwarded on seg_stop
//   flush             drop all queued, not yet fetched commands
//   seg_positions     {startX, startY, endX, endY} to the engine
//   seg_start         one-cycle start pulse (primSelect)
//   seg_stop          engine stop (= fb_stall)
//   seg_done          lineDone from the engine
//   prim_done         pulse after the last segment of a primitive completes
//   cmd_err           pulse after a reserved-type command is fetched
//   busy              FIFO non-empty or sequencer not idle
//
// Optional feature macro PRIM_COUNT_EN adds prim_count / seg_count
// wrapping 16-bit event counters.
module prim_sequencer #(
  parameter int CMD_DEPTH = 4
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_type,
  input  logic [18:0] cmd_v0,
  input  logic [18:0] cmd_v1,
  input  logic [18:0] cmd_v2,
  input  logic        fb_stall,
  input  logic        flush,
  output logic [37:0] seg_positions,
  output logic        seg_start,
  output logic        seg_stop,
  input  logic        seg_done,
  output logic        prim_done,
  output logic        cmd_err,
  output logic        busy
`ifdef PRIM_COUNT_EN
  ,
  output logic [15:0] prim_count,
  output logic [15:0] seg_count
`endif
);

  localparam int AW = $clog2(CMD_DEPTH);

  typedef struct packed {
    logic [1:0]  typ;
    logic [18:0] v0;
    logic [18:0] v1;
    logic [18:0] v2;
  } cmd_t;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_ISSUE, S_WAIT} state_t;

  // ---------------------------------------------------------------- FIFO
  cmd_t        mem [CMD_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr, fifo_cnt;
  logic        empty, full, push, pop;
  cmd_t        head;

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign fifo_cnt  = wr_ptr - rd_ptr;
  assign cmd_ready = !full;
  // A push coinciding with flush is discarded.
  assign push      = cmd_valid && !full && !flush;
  assign head      = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= '{cmd_type, cmd_v0, cmd_v1, cmd_v2};
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (flush)    rd_ptr <= wr_ptr;
      else if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // ---------------------------------------------------------------- FSM
  state_t      state, state_d;
  cmd_t        hold;
  logic [1:0]  seg_idx, last_idx;
  logic        wait_armed;   // low during the first WAIT cycle
  logic        load, seg_inc, prim_done_d, cmd_err_d, more;

  // Another entry remains behind the head being popped.
  assign more = (fifo_cnt != {{AW{1'b0}}, 1'b1}) && !flush;

  always_comb begin
    case (hold.typ)
      2'd1:    last_idx = 2'd2;
      2'd2:    last_idx = 2'd3;
      default: last_idx = 2'd0;
    endcase
  end

  always_comb begin
    state_d     = state;
    pop         = 1'b0;
    load        = 1'b0;
    seg_start   = 1'b0;
    seg_inc     = 1'b0;
    prim_done_d = 1'b0;
    cmd_err_d   = 1'b0;
    case (state)
      S_IDLE:
        if (!empty && !flush) state_d = S_FETCH;
      S_FETCH:
        // A flush in the previous cycle can leave nothing to fetch.
        if (empty) state_d = S_IDLE;
        else begin
          pop  = 1'b1;
          load = 1'b1;
          if (head.typ == 2'd3) begin
            cmd_err_d = 1'b1;
            state_d   = more ? S_FETCH : S_IDLE;
          end else begin
            state_d = S_ISSUE;
          end
        end
      S_ISSUE:
        if (!fb_stall) begin
          seg_start = 1'b1;
          state_d   = S_WAIT;
        end
      S_WAIT:
        if (seg_done && wait_armed) begin
          if (seg_idx == last_idx) begin
            prim_done_d = 1'b1;
            state_d     = (!empty && !flush) ? S_FETCH : S_IDLE;
          end else begin
            seg_inc = 1'b1;
            state_d = S_ISSUE;
          end
        end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= S_IDLE;
      hold       <= '0;
      seg_idx    <= '0;
      wait_armed <= 1'b0;
      prim_done  <= 1'b0;
      cmd_err    <= 1'b0;
    end else begin
      state      <= state_d;
      prim_done  <= prim_done_d;
      cmd_err    <= cmd_err_d;
      wait_armed <= (state == S_WAIT);
      if (load) begin
        hold    <= head;
        seg_idx <= '0;
      end else if (seg_inc) begin
        seg_idx <= seg_idx + 1'b1;
      end
    end
  end

  // ------------------------------------------------------- segment table
  logic [9:0] x0, x1, x2, sx, ex;
  logic [8:0] y0, y1, y2, sy, ey;

  assign {x0, y0} = hold.v0;
  assign {x1, y1} = hold.v1;
  assign {x2, y2} = hold.v2;

  always_comb begin
    sx = x0; sy = y0; ex = x1; ey = y1;
    if (hold.typ == 2'd1) begin
      case (seg_idx)
        2'd1:    begin sx = x1; sy = y1; ex = x2; ey = y2; end
        2'd2:    begin sx = x2; sy = y2; ex = x0; ey = y0; end
        default: begin sx = x0; sy = y0; ex = x1; ey = y1; end
      endcase
    end else if (hold.typ == 2'd2) begin
      // Rectangle corners walked clockwise from (x0,y0).
      case (seg_idx)
        2'd0:    begin sx = x0; sy = y0; ex = x1; ey = y0; end
        2'd1:    begin sx = x1; sy = y0; ex = x1; ey = y1; end
        2'd2:    begin sx = x1; sy = y1; ex = x0; ey = y1; end
        default: begin sx = x0; sy = y1; ex = x0; ey = y0; end
      endcase
    end
  end

  assign seg_positions = {sx, sy, ex, ey};
  assign seg_stop      = fb_stall;
  assign busy          = !empty || (state != S_IDLE);

`ifdef PRIM_COUNT_EN
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      prim_count <= '0;
      seg_count  <= '0;
    end else begin
      if (prim_done) prim_count <= prim_count + 16'd1;
      if (seg_start) seg_count  <= seg_count + 16'd1;
    end
  end
`else
  // Event counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_prim_sequencer.sv
// Testbench for prim_sequencer: directed commands, an engine responder that
// acknowledges segments after a programmable delay, and a transaction-level
// model that expands commands into expected segments and checks the DUT on
// every cycle (sampled on the falling edge).
module tb_prim_sequencer;

  typedef struct packed {
    logic [1:0]  typ;
    logic [18:0] v0;
    logic [18:0] v1;
    logic [18:0] v2;
  } tcmd_t;

  logic        clk = 1'b0;
  logic        n_rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_type = '0;
  logic [18:0] cmd_v0 = '0, cmd_v1 = '0, cmd_v2 = '0;
  logic        fb_stall = 1'b0;
  logic        flush = 1'b0;
  logic [37:0] seg_positions;
  logic        seg_start, seg_stop;
  logic        seg_done;
  logic        prim_done, cmd_err, busy;

  prim_sequencer #(.CMD_DEPTH(4)) dut (
    .clk(clk), .n_rst(n_rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
    .cmd_v0(cmd_v0), .cmd_v1(cmd_v1), .cmd_v2(cmd_v2),
    .fb_stall(fb_stall), .flush(flush),
    .seg_positions(seg_positions), .seg_start(seg_start), .seg_stop(seg_stop),
    .seg_done(seg_done), .prim_done(prim_done), .cmd_err(cmd_err), .busy(busy)
  );

  initial forever #5 clk = ~clk;

  int n_cmp = 0, n_fail = 0;

  // model state
  tcmd_t       cmd_q[$];
  logic [38:0] seg_q[$];          // {last, positions}
  bit          outstanding = 0, out_last = 0, pd_next = 0;
  int          err_exp = 0, err_seen = 0, ss_seen = 0, pd_seen = 0;
  logic [37:0] last_pos = '0;
  bit          ack_en = 1;
  int          ack_delay = 3;

  task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  function automatic logic [18:0] vx(int x, int y);
    return {x[9:0], y[8:0]};
  endfunction

  function automatic tcmd_t mk(logic [1:0] t, logic [18:0] a, logic [18:0] b, logic [18:0] c);
    tcmd_t r;
    r.typ = t; r.v0 = a; r.v1 = b; r.v2 = c;
    return r;
  endfunction

  function automatic int nseg(logic [1:0] t);
    case (t)
      2'd0: return 1;
      2'd1: return 3;
      2'd2: return 4;
      default: return 0;
    endcase
  endfunction

  // Primitive = polygon of corner points; segment i joins point i to i+1.
  function automatic logic [37:0] seg_of(tcmd_t c, int i);
    logic [18:0] p[4];
    int n;
    n = 2;
    p[0] = c.v0; p[1] = c.v1; p[2] = '0; p[3] = '0;
    if (c.typ == 2'd1) begin
      n = 3; p[2] = c.v2;
    end else if (c.typ == 2'd2) begin
      n = 4;
      p[0] = {c.v0[18:9], c.v0[8:0]};
      p[1] = {c.v1[18:9], c.v0[8:0]};
      p[2] = {c.v1[18:9], c.v1[8:0]};
      p[3] = {c.v0[18:9], c.v1[8:0]};
    end
    return {p[i], p[(i + 1) % n]};
  endfunction

  // Per-cycle compare process.
  initial begin : cmp
    tcmd_t       c;
    logic [38:0] e;
    forever begin
      @(negedge clk);
      if (n_rst) begin
        chk("seg_stop", 64'(seg_stop), 64'(fb_stall));
        chk("prim_done", 64'(prim_done), 64'(pd_next));
        pd_next = 0;
        if (prim_done) pd_seen++;
        if (cmd_err) err_seen++;
        if (seg_start) begin
          ss_seen++;
          chk("start_unstalled", 64'(fb_stall), 64'(0));
          if (seg_q.size() == 0) begin
            while (cmd_q.size() > 0 && cmd_q[0].typ == 2'd3) begin
              cmd_q.delete(0);
              err_exp++;
            end
            if (cmd_q.size() > 0) begin
              c = cmd_q.pop_front();
              for (int i = 0; i < nseg(c.typ); i++)
                seg_q.push_back({(i == nseg(c.typ) - 1), seg_of(c, i)});
            end
          end
          if (seg_q.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL unexpected_seg_start: got seg_start=1 required 0");
          end else begin
            e = seg_q.pop_front();
            chk("seg_positions", 64'(seg_positions), 64'(e[37:0]));
            outstanding = 1;
            out_last    = e[38];
          end
          last_pos = seg_positions;
        end
        if (seg_done && outstanding) begin
          outstanding = 0;
          pd_next     = out_last;
        end
      end
    end
  end

  // Engine responder: ack each segment ack_delay cycles after its start.
  initial begin : resp
    int age;
    bit pend, go;
    seg_done = 1'b0; pend = 0; age = 0;
    forever begin
      @(negedge clk);
      if (!n_rst) begin pend = 0; age = 0; end
      else if (seg_start) begin pend = 1; age = 0; end
      else if (pend) age++;
      go = n_rst && pend && ack_en && (age >= ack_delay - 1);
      @(posedge clk); #1;
      seg_done = go;
      if (go) pend = 0;
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push(logic [1:0] t, logic [18:0] a, logic [18:0] b, logic [18:0] c, bit acc);
    cmd_valid = 1'b1; cmd_type = t; cmd_v0 = a; cmd_v1 = b; cmd_v2 = c;
    chk("cmd_ready", 64'(cmd_ready), 64'(acc));
    if (acc) cmd_q.push_back(mk(t, a, b, c));
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(int max);
    int k;
    k = 0;
    tick();
    while (busy && k < max) begin tick(); k++; end
    if (busy) begin
      n_cmp++; n_fail++;
      $display("FAIL wait_idle_timeout: got busy=1 required 0 within %0d cycles", max);
    end
    tick(); tick();
  endtask

  task automatic chk_reset_outs(string tag);
    chk({tag, "_pos"},   64'(seg_positions), 64'(0));
    chk({tag, "_start"}, 64'(seg_start), 64'(0));
    chk({tag, "_pd"},    64'(prim_done), 64'(0));
    chk({tag, "_err"},   64'(cmd_err), 64'(0));
    chk({tag, "_busy"},  64'(busy), 64'(0));
    chk({tag, "_ready"}, 64'(cmd_ready), 64'(1));
  endtask

  int ss0, pd0, e0, k;

  initial begin : main
    #1 n_rst = 1'b0;
    #1 chk_reset_outs("reset");
    @(posedge clk); @(posedge clk); #1 n_rst = 1'b1;
    tick();

    // pin the model against hand-computed segments
    chk("model_tri1", 64'(seg_of(mk(2'd1, vx(0, 0), vx(100, 0), vx(50, 80)), 1)),
        64'({10'd100, 9'd0, 10'd50, 9'd80}));
    chk("model_rect3", 64'(seg_of(mk(2'd2, vx(5, 5), vx(15, 9), '0), 3)),
        64'({10'd5, 9'd9, 10'd5, 9'd5}));
    chk("model_nseg_rect", 64'(nseg(2'd2)), 64'(4));

    // 1: single line, latency and completion
    ack_en = 1; ack_delay = 3;
    ss0 = ss_seen; pd0 = pd_seen;
    push(2'd0, vx(10, 20), vx(30, 25), '0, 1);
    chk("t1_busy", 64'(busy), 64'(1));
    chk("t1_no_start_n", 64'(seg_start), 64'(0));
    tick();
    chk("t1_no_start_n1", 64'(seg_start), 64'(0));
    tick();
    chk("t1_start_n2", 64'(seg_start), 64'(1));
    chk("t1_pos", 64'(seg_positions), 64'({10'd10, 9'd20, 10'd30, 9'd25}));
    wait_idle(100);
    chk("t1_segs", 64'(ss_seen - ss0), 64'(1));
    chk("t1_pd", 64'(pd_seen - pd0), 64'(1));
    chk("t1_idle", 64'(busy), 64'(0));

    // 2: triangle, ack after 5 cycles
    ack_delay = 5;
    ss0 = ss_seen; pd0 = pd_seen;
    push(2'd1, vx(0, 0), vx(100, 0), vx(50, 80), 1);
    wait_idle(300);
    chk("t2_segs", 64'(ss_seen - ss0), 64'(3));
    chk("t2_pd", 64'(pd_seen - pd0), 64'(1));
    chk("t2_last", 64'(last_pos), 64'({10'd50, 9'd80, 10'd0, 9'd0}));

    // 3: rectangle
    ack_delay = 2;
    ss0 = ss_seen; pd0 = pd_seen;
    push(2'd2, vx(5, 5), vx(15, 9), '0, 1);
    wait_idle(300);
    chk("t3_segs", 64'(ss_seen - ss0), 64'(4));
    chk("t3_pd", 64'(pd_seen - pd0), 64'(1));
    chk("t3_last", 64'(last_pos), 64'({10'd5, 9'd9, 10'd5, 9'd5}));

    // 4: stall before push, release, toggle during WAIT
    ack_en = 0;
    ss0 = ss_seen; pd0 = pd_seen;
    fb_stall = 1'b1;
    push(2'd0, vx(1, 2), vx(3, 4), '0, 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t4_stall_nostart", 64'(seg_start), 64'(0));
      chk("t4_stall_stop", 64'(seg_stop), 64'(1));
    end
    fb_stall = 1'b0; #1;
    chk("t4_release_start", 64'(seg_start), 64'(1));
    tick();
    fb_stall = 1'b1; #1;
    chk("t4_wait_stop1", 64'(seg_stop), 64'(1));
    tick();
    fb_stall = 1'b0; #1;
    chk("t4_wait_stop0", 64'(seg_stop), 64'(0));
    tick(); fb_stall = 1'b1;
    tick(); fb_stall = 1'b0;
    tick();
    chk("t4_one_start", 64'(ss_seen - ss0), 64'(1));
    ack_en = 1;
    wait_idle(100);
    chk("t4_pd", 64'(pd_seen - pd0), 64'(1));

    // 5: fill the FIFO with no acks, overflow, flush
    ack_en = 0;
    ss0 = ss_seen; pd0 = pd_seen;
    for (int i = 1; i <= 5; i++) push(2'd0, vx(i, i), vx(i + 1, i + 1), '0, 1);
    push(2'd0, vx(60, 60), vx(61, 61), '0, 0);
    chk("t5_full", 64'(cmd_ready), 64'(0));
    chk("t5_busy", 64'(busy), 64'(1));
    flush = 1'b1;
    cmd_q.delete();
    tick();
    flush = 1'b0;
    chk("t5_ready_after_flush", 64'(cmd_ready), 64'(1));
    chk("t5_busy_wait", 64'(busy), 64'(1));
    ack_en = 1;
    wait_idle(100);
    chk("t5_segs", 64'(ss_seen - ss0), 64'(1));
    chk("t5_pd", 64'(pd_seen - pd0), 64'(1));
    chk("t5_idle", 64'(busy), 64'(0));
    for (int i = 0; i < 5; i++) tick();
    chk("t5_no_more", 64'(ss_seen - ss0), 64'(1));

    // 6: reserved type, then a line; reset during WAIT
    ack_en = 0;
    ss0 = ss_seen; e0 = err_seen;
    push(2'd3, vx(1, 1), vx(2, 2), vx(3, 3), 1);
    push(2'd0, vx(7, 8), vx(9, 10), '0, 1);
    k = 0;
    while (ss_seen == ss0 && k < 20) begin tick(); k++; end
    chk("t6_line_started", 64'(ss_seen - ss0), 64'(1));
    chk("t6_err_once", 64'(err_seen - e0), 64'(1));
    chk("t6_err_model", 64'(err_seen), 64'(err_exp));
    chk("t6_line_pos", 64'(last_pos), 64'({10'd7, 9'd8, 10'd9, 9'd10}));
    tick();
    n_rst = 1'b0; #1;
    chk_reset_outs("t6_rst");
    seg_q.delete(); cmd_q.delete();
    outstanding = 0; pd_next = 0;
    tick();
    n_rst = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("t6_idle_after_rst", 64'(busy), 64'(0));
    chk("t6_no_restart", 64'(ss_seen - ss0), 64'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
